tb_rd_map_seq: RTL and testbench
================================

Name: tb_rd_map_seq

Overview:
Sequenced read-and-map engine between a temp-buffer (TB) read port and the RSA operand buses (B, B_CONS, …).
- Accepts one burst command and issues strided TB read addresses.
- Tracks the BRAM read latency and applies the per-lane mapping: forward, reversed over the active lanes, or zero.
- Routes each mapped row to one of NUM_DST destination buses with valid/last framing and a done pulse.

Parameters:
L, 4, TB read-port lanes.
Y, 4, output lanes per destination bus.
RSA_DW, 16, lane data width.
RSA_AW, 10, TB address width.
RD_LAT, 2, TB read latency in cycles (≥1).
NUM_DST, 2, number of destination buses (0=B, 1=B_CONS).
LEN_W, 8, burst-length width.

Ports:
clk  in  1  clock, all logic on rising edge.
sys_rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE.
cmd_dst  in  $clog2(NUM_DST)  destination select.
cmd_dir  in  2  00 IDLE, 01 POS, 10 NEG, 11 NEW.
cmd_base  in  RSA_AW  first TB address.
cmd_stride  in  RSA_AW  address increment per row.
cmd_len  in  LEN_W  rows to read.
cmd_lanes  in  $clog2(L)+1  active lane count.
TB_enb  out  1  TB read enable.
TB_addrb  out  RSA_AW  TB read address.
TB_doutb  in  L*RSA_DW  TB read data.
map_dout  out  NUM_DST*Y*RSA_DW  mapped rows, one Y*RSA_DW slice per destination.
map_valid  out  NUM_DST  per-destination beat valid.
map_last  out  1  final beat of the burst.
busy  out  1  not IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asserting sys_rst_n low immediately clears all state and outputs to 0. FSM goes to IDLE and the valid pipeline is flushed. cmd_ready=1 once reset is released. This applies mid-burst too; no partial beats appear after release.
- FSM states are IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - A command is accepted on cmd_valid&&cmd_ready.
  - At acceptance, latch dst, dir, base, stride, len, and lanes. cmd_lanes>L is clamped to L.
  - If len==0 or dir==IDLE, go to FIN; otherwise go to ISSUE.
- ISSUE:
  - Each cycle, drive TB_enb=1 and TB_addrb=base+k*stride mod 2^RSA_AW (wraps silently), for k=0..len-1.
  - Use an incrementing address register, not a multiplier.
  - After k=len-1, go to DRAIN.
- DRAIN:
  - TB_enb=0.
  - Wait until the beat tagged last has left the output register, then go to IDLE.
- FIN: done=1 for one cycle, no beats issued, then IDLE.
- Valid pipeline:
  - An RD_LAT-deep shift register carries {valid,last} alongside each read.
  - TB_doutb for an enable in cycle c is sampled in cycle c+RD_LAT.
  - Mapped data is registered, so map output appears in cycle c+RD_LAT+1.
  - First map_valid occurs RD_LAT+2 cycles after the accept edge. Beats are back-to-back with no bubbles.
- Lane map, for output lane i in 0..Y-1 with n=lanes:
  - POS: out[i]=in[i] if i<n, else 0.
  - NEG: out[i]=in[n-1-i] if i<n, else 0.
  - NEW: all zero, but valid still asserted.
  - Any source index ≥L yields 0.
- Routing:
  - Only slice dst carries data and map_valid[dst].
  - Other slices and valid bits are 0.
  - All slices are 0 whenever no beat is valid.
- map_last=1 with the final beat. done=1 in that same cycle, and cmd_ready returns the next cycle.
- Commands are not accepted while busy; cmd_valid is ignored outside IDLE.

Decomposition:
- Shared package: DIR_IDLE/POS/NEG/NEW codes, FSM state encodings, DST_B=0 / DST_B_CONS=1 constants.
- One sub-module, tb_lane_map: combinational permutation/zero-mask of L lanes to Y lanes given dir and lanes. The parent registers its output.

Test Plan:
- POS, dst0, base 0x010, stride 1, len 3, lanes 4, RD_LAT 2 -> TB_addrb 0x010/0x011/0x012 in cycles T+1..T+3. map_valid=01 in T+4..T+6 with lanes equal to input. map_last and done at T+6. map_valid[1]=0 throughout.
- NEG, lanes 3, TB_doutb lanes {0x0004,0x0003,0x0002,0x0001} (lane3..lane0) -> out lane0=0x0003, lane1=0x0002, lane2=0x0001, lane3=0x0000.
- Wrap/stride: base 0x3FE, stride 1, len 4 -> addresses 0x3FE,0x3FF,0x000,0x001. Then base 0, stride 5, len 3 -> 0x000,0x005,0x00A.
- len 0, and dir IDLE with len 5 -> no TB_enb, no map_valid, done one cycle after accept, cmd_ready high the following cycle.
- NEW to dst1, len 2 -> map_valid=10 for 2 cycles with all-zero data; lanes 9 on the same burst is clamped to 4.
- Reset pulled low during ISSUE at k=1 -> all outputs 0 immediately and no map_valid after release. A fresh POS len 1 command then completes normally.

Source files
------------

// File: rtl/tb_rd_map_seq_pkg.sv
// Shared types and constants for the TB read-and-map engine.
package tb_rd_map_seq_pkg;

  localparam int unsigned L       = 4;
  localparam int unsigned Y       = 4;
  localparam int unsigned RSA_DW  = 16;
  localparam int unsigned RSA_AW  = 10;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned NUM_DST = 2;
  localparam int unsigned LEN_W   = 8;

  localparam int unsigned DST_W  = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam int unsigned LANE_W = $clog2(L) + 1;
  localparam int unsigned IN_W   = L * RSA_DW;
  localparam int unsigned ROW_W  = Y * RSA_DW;
  localparam int unsigned MAP_W  = NUM_DST * ROW_W;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [DST_W-1:0] DST_B      = DST_W'(0);
  localparam logic [DST_W-1:0] DST_B_CONS = DST_W'(1);

  // Burst parameters held for the whole burst; the base lives in the address register.
  typedef struct packed {
    logic [DST_W-1:0]  dst;
    dir_e              dir;
    logic [RSA_AW-1:0] stride;
    logic [LEN_W-1:0]  len;
    logic [LANE_W-1:0] lanes;
  } cmd_t;

  function automatic logic [LANE_W-1:0] clamp_lanes(input logic [LANE_W-1:0] n);
    return (n > LANE_W'(L)) ? LANE_W'(L) : n;
  endfunction

endpackage

// File: rtl/tb_rd_map_seq_if.sv
// Command, TB read-port and mapped-output signals of the read-and-map engine.
interface tb_rd_map_seq_if;
  import tb_rd_map_seq_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DST_W-1:0]     cmd_dst;
  logic [1:0]           cmd_dir;
  logic [RSA_AW-1:0]    cmd_base;
  logic [RSA_AW-1:0]    cmd_stride;
  logic [LEN_W-1:0]     cmd_len;
  logic [LANE_W-1:0]    cmd_lanes;
  logic                 TB_enb;
  logic [RSA_AW-1:0]    TB_addrb;
  logic [IN_W-1:0]      TB_doutb;
  logic [MAP_W-1:0]     map_dout;
  logic [NUM_DST-1:0]   map_valid;
  logic                 map_last;
  logic                 busy;
  logic                 done;

  modport slave (
    input  cmd_valid, cmd_dst, cmd_dir, cmd_base, cmd_stride, cmd_len, cmd_lanes, TB_doutb,
    output cmd_ready, TB_enb, TB_addrb, map_dout, map_valid, map_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_dst, cmd_dir, cmd_base, cmd_stride, cmd_len, cmd_lanes, TB_doutb,
    input  cmd_ready, TB_enb, TB_addrb, map_dout, map_valid, map_last, busy, done
  );

endinterface

// File: rtl/tb_rd_map_seq_lane_map.sv
// Combinational lane permutation: forward, reversed over the active lanes, or zero.
module tb_lane_map
  import tb_rd_map_seq_pkg::*;
(
  input  logic [IN_W-1:0]   din,
  input  dir_e              dir,
  input  logic [LANE_W-1:0] lanes,
  output logic [ROW_W-1:0]  dout_c
);

  int n;
  int src;

  always_comb begin
    dout_c = '0;
    n      = int'(lanes);
    src    = 0;
    for (int i = 0; i < int'(Y); i++) begin
      if (i < n) begin
        src = (dir == DIR_NEG) ? (n - 1 - i) : i;
        // Source lanes beyond the read port width map to zero.
        if ((dir == DIR_POS || dir == DIR_NEG) && src < int'(L)) begin
          dout_c[i*RSA_DW +: RSA_DW] = din[src*RSA_DW +: RSA_DW];
        end
      end
    end
  end

endmodule

// File: rtl/tb_rd_map_seq.sv
// Burst engine: strided TB reads, latency-matched valid pipeline, lane mapping
// and routing of each mapped row to one destination bus.
module tb_rd_map_seq
  import tb_rd_map_seq_pkg::*;
(
  input  logic           clk,
  input  logic           sys_rst_n,
  tb_rd_map_seq_if.slave bus
);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [RSA_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    k_q, k_d;
  logic                tb_enb_q, tb_enb_d;
  logic [RD_LAT-1:0]   pv_q, pv_d;
  logic [RD_LAT-1:0]   pl_q, pl_d;
  logic [MAP_W-1:0]    map_dout_q, map_dout_d;
  logic [NUM_DST-1:0]  map_valid_q, map_valid_d;
  logic                map_last_q, map_last_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;

  logic [ROW_W-1:0]    mapped_c;
  logic                issue_last_c;
  logic                beat_last_c;
  dir_e                in_dir_c;

  assign in_dir_c     = dir_e'(bus.cmd_dir);
  assign issue_last_c = (k_q == cmd_q.len - LEN_W'(1));
  assign beat_last_c  = pv_q[RD_LAT-1] && pl_q[RD_LAT-1];

  tb_lane_map u_lane_map (
    .din    (bus.TB_doutb),
    .dir    (cmd_q.dir),
    .lanes  (cmd_q.lanes),
    .dout_c (mapped_c)
  );

  // Control FSM: accept, address issue, drain, zero-length finish.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    k_d      = k_q;
    tb_enb_d = 1'b0;
    done_d   = beat_last_c;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_d.dst    = bus.cmd_dst;
          cmd_d.dir    = in_dir_c;
          cmd_d.stride = bus.cmd_stride;
          cmd_d.len    = bus.cmd_len;
          cmd_d.lanes  = clamp_lanes(bus.cmd_lanes);
          if (bus.cmd_len == '0 || in_dir_c == DIR_IDLE) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            tb_enb_d = 1'b1;
            addr_d   = bus.cmd_base;
            k_d      = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (issue_last_c) begin
          state_d = ST_DRAIN;
        end else begin
          tb_enb_d = 1'b1;
          addr_d   = addr_q + cmd_q.stride;
          k_d      = k_q + LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (map_last_q) state_d = ST_IDLE;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // {valid,last} travel alongside each read for RD_LAT cycles.
  always_comb begin
    pv_d    = '0;
    pl_d    = '0;
    pv_d[0] = tb_enb_q;
    pl_d[0] = tb_enb_q && issue_last_c;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  // Only the selected destination slice carries data; everything else is zero.
  always_comb begin
    map_dout_d  = '0;
    map_valid_d = '0;
    map_last_d  = 1'b0;
    if (pv_q[RD_LAT-1]) begin
      map_dout_d[int'(cmd_q.dst)*ROW_W +: ROW_W] = mapped_c;
      map_valid_d[cmd_q.dst]                     = 1'b1;
      map_last_d                                 = pl_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      k_q         <= '0;
      tb_enb_q    <= 1'b0;
      pv_q        <= '0;
      pl_q        <= '0;
      map_dout_q  <= '0;
      map_valid_q <= '0;
      map_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      k_q         <= k_d;
      tb_enb_q    <= tb_enb_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      map_dout_q  <= map_dout_d;
      map_valid_q <= map_valid_d;
      map_last_q  <= map_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.TB_enb    = tb_enb_q;
  assign bus.TB_addrb  = addr_q;
  assign bus.map_dout  = map_dout_q;
  assign bus.map_valid = map_valid_q;
  assign bus.map_last  = map_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_tb_rd_map_seq.sv
// Self-checking bench: vector table of bursts, BRAM model and beat scoreboard.
module tb_tb_rd_map_seq;
  import tb_rd_map_seq_pkg::*;

  logic clk;
  logic sys_rst_n;
  int   checks;
  int   errors;
  bit   mon_en;

  tb_rd_map_seq_if bus ();

  tb_rd_map_seq dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [MAP_W-1:0]   dout;
    logic [NUM_DST-1:0] valid;
    logic               last;
  } beat_t;

  typedef struct {
    dir_e              dir;
    logic [DST_W-1:0]  dst;
    logic [RSA_AW-1:0] base;
    logic [RSA_AW-1:0] stride;
    logic [LEN_W-1:0]  len;
    logic [LANE_W-1:0] lanes;
    int                exp_done;
    int                exp_beats;
    logic [ROW_W-1:0]  exp_first;
    bit                spam;
  } vec_t;

  logic [RSA_AW-1:0] exp_addr[$];
  beat_t             exp_beat[$];

  // TB memory: lane j of address a holds (a<<4)+j+1.
  function automatic logic [IN_W-1:0] tb_word(input logic [RSA_AW-1:0] a);
    logic [IN_W-1:0] w;
    w = '0;
    for (int j = 0; j < int'(L); j++) w[j*RSA_DW +: RSA_DW] = RSA_DW'((32'(a) << 4) + 32'(j) + 1);
    return w;
  endfunction

  logic [RSA_AW-1:0] a_pipe[RD_LAT];
  always @(posedge clk) begin
    a_pipe[0] <= bus.TB_addrb;
    for (int i = 1; i < int'(RD_LAT); i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign bus.TB_doutb = tb_word(a_pipe[RD_LAT-1]);

  task automatic chk(input string nm, input logic [MAP_W-1:0] act, input logic [MAP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] model_row(input dir_e d, input logic [LANE_W-1:0] lanes,
                                                 input logic [IN_W-1:0] din);
    logic [RSA_DW-1:0] lane_in[L];
    logic [ROW_W-1:0]  r;
    int                n;
    n = (int'(lanes) > int'(L)) ? int'(L) : int'(lanes);
    for (int j = 0; j < int'(L); j++) lane_in[j] = din[j*RSA_DW +: RSA_DW];
    r = '0;
    for (int i = 0; i < int'(Y); i++) begin
      if (i < n && d == DIR_POS) r[i*RSA_DW +: RSA_DW] = lane_in[i];
      if (i < n && d == DIR_NEG) r[i*RSA_DW +: RSA_DW] = lane_in[n-1-i];
    end
    return r;
  endfunction

  task automatic push_model(input vec_t v);
    logic [RSA_AW-1:0] a;
    beat_t             b;
    if (v.len == 0 || v.dir == DIR_IDLE) return;
    for (int k = 0; k < int'(v.len); k++) begin
      a = RSA_AW'(32'(v.base) + 32'(k) * 32'(v.stride));
      exp_addr.push_back(a);
      b.dout = '0;
      b.dout[int'(v.dst)*ROW_W +: ROW_W] = model_row(v.dir, v.lanes, tb_word(a));
      b.valid = NUM_DST'(1) << v.dst;
      b.last  = (k == int'(v.len) - 1);
      exp_beat.push_back(b);
    end
  endtask

  // Scoreboard monitor: every issued address and every beat must be expected.
  always @(negedge clk) begin
    if (sys_rst_n === 1'b1 && mon_en) begin
      if (bus.TB_enb === 1'b1) begin
        if (exp_addr.size() == 0) chk("unexpected_TB_enb", MAP_W'(bus.TB_addrb), '1);
        else chk("TB_addrb", MAP_W'(bus.TB_addrb), MAP_W'(exp_addr.pop_front()));
      end
      if (bus.map_valid !== '0) begin
        if (exp_beat.size() == 0) chk("unexpected_beat", MAP_W'(bus.map_valid), '0);
        else begin
          beat_t e;
          e = exp_beat.pop_front();
          chk("map_dout", bus.map_dout, e.dout);
          chk("map_valid", MAP_W'(bus.map_valid), MAP_W'(e.valid));
          chk("map_last", MAP_W'(bus.map_last), MAP_W'(e.last));
        end
      end else begin
        chk("idle_dout_zero", bus.map_dout, '0);
      end
    end
  end

  task automatic drive_cmd(input vec_t v);
    bus.cmd_valid  = 1'b1;
    bus.cmd_dst    = v.dst;
    bus.cmd_dir    = v.dir;
    bus.cmd_base   = v.base;
    bus.cmd_stride = v.stride;
    bus.cmd_len    = v.len;
    bus.cmd_lanes  = v.lanes;
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int first_enb, first_val, last_val, n_val, n_done, done_cyc, last_cyc, ready_cyc, w;
    logic rdy1;
    logic [ROW_W-1:0] first_slice;
    vec_t sp;
    first_enb = -1; first_val = -1; last_val = -1; n_val = 0; n_done = 0;
    done_cyc = -1; last_cyc = -1; ready_cyc = -1; rdy1 = 1'b1; first_slice = '0;
    @(negedge clk);
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready_wait"}, MAP_W'(bus.cmd_ready), MAP_W'(1));
    drive_cmd(v);
    push_model(v);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = bus.cmd_ready;
      if (bus.TB_enb === 1'b1 && first_enb < 0) first_enb = c;
      if (bus.map_valid !== '0) begin
        if (first_val < 0) begin
          first_val   = c;
          first_slice = bus.map_dout[int'(v.dst)*ROW_W +: ROW_W];
        end
        n_val++;
        last_val = c;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      if (bus.map_last === 1'b1) last_cyc = c;
      if (done_cyc > 0 && ready_cyc < 0 && bus.cmd_ready === 1'b1) ready_cyc = c;
      // Offer a different command while busy; it must be ignored.
      if (v.spam && c == 2) begin
        sp = v;
        sp.base = RSA_AW'(10'h300);
        sp.len  = LEN_W'(2);
        drive_cmd(sp);
      end
      if (bus.done === 1'b1) bus.cmd_valid = 1'b0;
      if (ready_cyc > 0) break;
    end
    bus.cmd_valid = 1'b0;
    chk({nm, "_ready_low_c1"}, MAP_W'(rdy1), '0);
    chk({nm, "_done_cyc"}, MAP_W'(done_cyc), MAP_W'(v.exp_done));
    chk({nm, "_n_done"}, MAP_W'(n_done), MAP_W'(1));
    chk({nm, "_ready_cyc"}, MAP_W'(ready_cyc), MAP_W'(v.exp_done + 1));
    chk({nm, "_n_beats"}, MAP_W'(n_val), MAP_W'(v.exp_beats));
    if (v.exp_beats > 0) begin
      chk({nm, "_first_enb"}, MAP_W'(first_enb), MAP_W'(1));
      chk({nm, "_first_valid"}, MAP_W'(first_val), MAP_W'(RD_LAT + 2));
      chk({nm, "_last_with_done"}, MAP_W'(last_cyc), MAP_W'(done_cyc));
      chk({nm, "_contiguous"}, MAP_W'(last_val - first_val + 1), MAP_W'(v.exp_beats));
      chk({nm, "_first_row"}, MAP_W'(first_slice), MAP_W'(v.exp_first));
    end else begin
      chk({nm, "_no_enb"}, MAP_W'(first_enb), MAP_W'(-1));
      chk({nm, "_no_last"}, MAP_W'(last_cyc), MAP_W'(-1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t rv;
    int   n_enb, n_val;

    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    sys_rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dst = DST_B; bus.cmd_dir = DIR_IDLE;
    bus.cmd_base = '0; bus.cmd_stride = '0; bus.cmd_len = '0; bus.cmd_lanes = '0;

    //            dir      dst         base     stride   len    lanes  done beats first row
    vecs[0] = '{DIR_POS, DST_B,      10'h010, 10'h001, 8'd3, 3'd4, 6, 3, 64'h0104_0103_0102_0101, 1'b0};
    vecs[1] = '{DIR_NEG, DST_B,      10'h000, 10'h001, 8'd1, 3'd3, 4, 1, 64'h0000_0001_0002_0003, 1'b0};
    vecs[2] = '{DIR_POS, DST_B,      10'h3FE, 10'h001, 8'd4, 3'd2, 7, 4, 64'h0000_0000_3FE2_3FE1, 1'b0};
    vecs[3] = '{DIR_NEG, DST_B_CONS, 10'h000, 10'h005, 8'd3, 3'd4, 6, 3, 64'h0001_0002_0003_0004, 1'b0};
    vecs[4] = '{DIR_POS, DST_B,      10'h010, 10'h001, 8'd0, 3'd4, 1, 0, 64'h0,                   1'b0};
    vecs[5] = '{DIR_IDLE, DST_B,     10'h010, 10'h001, 8'd5, 3'd4, 1, 0, 64'h0,                   1'b0};
    vecs[6] = '{DIR_NEW, DST_B_CONS, 10'h020, 10'h001, 8'd2, 3'd7, 5, 2, 64'h0,                   1'b0};
    vecs[7] = '{DIR_POS, DST_B_CONS, 10'h040, 10'h003, 8'd5, 3'd7, 8, 5, 64'h0404_0403_0402_0401, 1'b1};
    vecs[8] = '{DIR_NEG, DST_B,      10'h200, 10'h3FF, 8'd3, 3'd1, 6, 3, 64'h0000_0000_0000_2001, 1'b0};
    vecs[9] = '{DIR_POS, DST_B,      10'h080, 10'h001, 8'd2, 3'd0, 5, 2, 64'h0,                   1'b0};

    #1;
    chk("rst_cmd_ready", MAP_W'(bus.cmd_ready), '0);
    chk("rst_TB_enb", MAP_W'(bus.TB_enb), '0);
    chk("rst_map_valid", MAP_W'(bus.map_valid), '0);
    chk("rst_busy_done", MAP_W'({bus.busy, bus.done, bus.map_last}), '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", MAP_W'(bus.cmd_ready), MAP_W'(1));
    chk("post_rst_busy", MAP_W'(bus.busy), '0);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while the second address of a burst is on the bus.
    @(negedge clk);
    rv = '{DIR_POS, DST_B, 10'h100, 10'h001, 8'd8, 3'd4, 0, 0, 64'h0, 1'b0};
    drive_cmd(rv);
    exp_addr.push_back(10'h100);
    exp_addr.push_back(10'h101);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_k1_enb", MAP_W'({bus.TB_enb, bus.TB_addrb}), MAP_W'({1'b1, 10'h101}));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_enb", MAP_W'(bus.TB_enb), '0);
    chk("rst_mid_addr", MAP_W'(bus.TB_addrb), '0);
    chk("rst_mid_busy", MAP_W'(bus.busy), '0);
    chk("rst_mid_ready", MAP_W'(bus.cmd_ready), '0);
    chk("rst_mid_map", bus.map_dout, '0);
    chk("rst_mid_flags", MAP_W'({bus.map_valid, bus.map_last, bus.done}), '0);
    repeat (2) @(posedge clk);
    exp_addr.delete();
    exp_beat.delete();
    @(negedge clk);
    sys_rst_n = 1'b1;
    n_enb = 0;
    n_val = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.TB_enb === 1'b1) n_enb++;
      if (bus.map_valid !== '0) n_val++;
    end
    chk("rst_release_no_enb", MAP_W'(n_enb), '0);
    chk("rst_release_no_beats", MAP_W'(n_val), '0);
    chk("rst_release_ready", MAP_W'(bus.cmd_ready), MAP_W'(1));

    rv = '{DIR_POS, DST_B, 10'h123, 10'h001, 8'd1, 3'd4, 4, 1, 64'h1234_1233_1232_1231, 1'b0};
    run_cmd(rv, "post_rst");

    repeat (4) @(negedge clk);
    chk("addr_queue_empty", MAP_W'(exp_addr.size()), '0);
    chk("beat_queue_empty", MAP_W'(exp_beat.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
